// File: rtl/spi_master_ctrl_if.sv
// Request/response bus between a command requester and the SPI master controller.
// The requester side uses the master modport; the controller uses the slave modport.
interface spi_master_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       err;
    logic       busy;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_data, err, busy
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_data, err, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master controller: turns one command per handshake into a framed SPI
// transfer (LEAD, 10-bit command/payload shift, optional turnaround and
// 8-bit read capture, then an SS_n-high gap). The SPI bit clock is clk itself.
module spi_master_ctrl #(
    parameter int unsigned TA  = 2,   // turnaround cycles before read capture (1..7)
    parameter int unsigned GAP = 1    // SS_n-high cycles after each frame (1..7)
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_ctrl_if.slave   bus,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEAD    = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_TURN    = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;

    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [3:0] TA_LAST  = 4'(TA - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    logic [2:0] state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic [1:0] op_q,        op_d;
    logic [9:0] frame_q,     frame_d;
    logic [7:0] rx_q,        rx_d;
    logic       rd_pend_q,   rd_pend_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q,  rsp_data_d;
    logic       err_q,       err_d;
    logic       ss_n_q,      ss_n_d;
    logic       mosi_q,      mosi_d;

    // Next-state, counter, shift and response logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 4'd1;
        op_d        = op_q;
        frame_d     = frame_q;
        rx_d        = rx_q;
        rd_pend_d   = rd_pend_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (bus.req_valid) begin
                    // A read-data with no address sent first has nothing to read.
                    if (bus.req_op == OP_RD_DATA && !rd_pend_q) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LEAD;
                        op_d    = bus.req_op;
                        frame_d = {bus.req_op, (bus.req_op == OP_RD_DATA) ? 8'h00 : bus.req_data};
                    end
                end
            end
            ST_LEAD: begin
                cnt_d   = 4'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                frame_d = {frame_q[8:0], 1'b0};
                if (cnt_q == 4'd9) begin
                    cnt_d = 4'd0;
                    if (op_q == OP_RD_DATA) begin
                        state_d = ST_TURN;
                    end else begin
                        state_d     = ST_GAP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 8'h00;
                        if (op_q == OP_RD_ADDR) begin
                            rd_pend_d = 1'b1;
                        end
                    end
                end
            end
            ST_TURN: begin
                if (cnt_q == TA_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == 4'd7) begin
                    cnt_d       = 4'd0;
                    state_d     = ST_GAP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {rx_q[6:0], MISO};
                    rd_pend_d   = 1'b0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase

        // SPI pins are registered from the next state so they change cleanly on the edge.
        ss_n_d = !(state_d == ST_LEAD || state_d == ST_SHIFT ||
                   state_d == ST_TURN || state_d == ST_CAPTURE);
        mosi_d = (state_d == ST_SHIFT) ? frame_d[9] : 1'b0;
    end

    // State registers with synchronous active-low reset; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            op_q        <= 2'b00;
            frame_q     <= 10'd0;
            rx_q        <= 8'h00;
            rd_pend_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            err_q       <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            frame_q     <= frame_d;
            rx_q        <= rx_d;
            rd_pend_q   <= rd_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.err       = err_q;
    assign SS_n          = ss_n_q;
    assign MOSI          = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a bus monitor records each SS_n-low
// frame (length, MOSI bits) and plays the slave's MISO byte; scenario tasks push
// expected responses to a scoreboard queue and pop them when rsp_valid appears.
module tb_spi_master_ctrl;

    localparam int TA  = 2;
    localparam int GAP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic MISO  = 1'b0;
    logic SS_n;
    logic MOSI;

    spi_master_ctrl_if bus();

    spi_master_ctrl #(.TA(TA), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  rsp;
        int          len;
        logic [31:0] bits;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;
    logic tb_rd_pend = 1'b0;

    // monitor state
    int          low_cnt = 0;
    int          hi_run = 0;
    int          busy_hi_run = 0;
    int          last_len = 0;
    int          last_gap = 0;
    int          last_busy_gap = 0;
    logic [31:0] cur_bits = '0;
    logic [31:0] last_bits = '0;
    int          frames = 0;
    int          rsp_cnt = 0;
    int          err_cnt = 0;
    int          ready_viol = 0;
    logic [7:0]  miso_byte = 8'h00;
    logic        prev_ss = 1'b1;

    // Frame monitor and slave model, sampled just after each rising edge.
    always @(posedge clk) begin
        int idx;
        #1;
        if (bus.req_ready !== !bus.busy) ready_viol++;
        if (bus.rsp_valid === 1'b1) rsp_cnt++;
        if (bus.err === 1'b1) err_cnt++;
        if (SS_n === 1'b0) begin
            if (prev_ss) begin
                last_gap      = hi_run;
                last_busy_gap = busy_hi_run;
                hi_run        = 0;
                busy_hi_run   = 0;
                low_cnt       = 0;
                cur_bits      = '0;
            end
            low_cnt++;
            cur_bits = {cur_bits[30:0], MOSI};
            // cycle 1 LEAD, 2..11 SHIFT, 12..11+TA TURN, 12+TA..19+TA CAPTURE
            if (low_cnt >= 12 + TA && low_cnt <= 19 + TA) begin
                idx  = 19 + TA - low_cnt;
                MISO = miso_byte[idx[2:0]];
            end else if (low_cnt >= 12 && low_cnt < 12 + TA) begin
                MISO = 1'b1;  // junk during turnaround must be ignored
            end else begin
                MISO = 1'b0;
            end
        end else begin
            if (!prev_ss) begin
                last_len  = low_cnt;
                last_bits = cur_bits;
                frames++;
            end
            hi_run++;
            if (bus.busy === 1'b1) busy_hi_run++;
            MISO = 1'b0;
        end
        prev_ss = SS_n;
    end

    function automatic exp_t mk_exp(input logic [1:0] op, input logic [7:0] data,
                                    input logic [7:0] miso);
        exp_t e;
        logic [9:0] fr;
        fr   = {op, (op == 2'b11) ? 8'h00 : data};
        e.op = op;
        if (op == 2'b11) begin
            e.len  = 19 + TA;
            e.bits = 32'(fr) << (TA + 8);
            e.rsp  = miso;
        end else begin
            e.len  = 11;
            e.bits = 32'(fr);
            e.rsp  = 8'h00;
        end
        return e;
    endfunction

    // Present a command and wait for the handshake; returns at the negedge after it.
    task automatic drive_cmd(input logic [1:0] op, input logic [7:0] data,
                             input bit hold, output bit ok);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge clk);
        ok = bus.req_ready;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        for (int i = 0; i < 200 && bus.rsp_valid !== 1'b1; i++) @(negedge clk);
        ok = (bus.rsp_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (SS_n !== 1'b1)           begin errors++; $display("FAIL rst_ss_n got=%b want=1", SS_n); end
        if (MOSI !== 1'b0)           begin errors++; $display("FAIL rst_mosi got=%b want=0", MOSI); end
        if (bus.rsp_valid !== 1'b0)  begin errors++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
        if (bus.rsp_data !== 8'h00)  begin errors++; $display("FAIL rst_rsp_data got=%02h want=00", bus.rsp_data); end
        if (bus.err !== 1'b0)        begin errors++; $display("FAIL rst_err got=%b want=0", bus.err); end
        if (bus.busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1)  begin errors++; $display("FAIL rst_req_ready got=%b want=1", bus.req_ready); end
        tb_rd_pend = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_reject(input string name);
        bit ok;
        int f0, e0, bad;
        f0 = frames;
        e0 = err_cnt;
        drive_cmd(2'b11, 8'h00, 1'b0, ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL %s_handshake got=timeout want=accepted", name); end
        if (bus.err !== 1'b1) begin errors++; $display("FAIL %s_err got=%b want=1", name, bus.err); end
        if (bus.busy !== 1'b0 || SS_n !== 1'b1)
            begin errors++; $display("FAIL %s_idle got busy=%b ss_n=%b want busy=0 ss_n=1", name, bus.busy, SS_n); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got=%b want=1", name, bus.req_ready); end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (SS_n !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        checks += 2;
        if (bad != 0 || frames != f0)
            begin errors++; $display("FAIL %s_no_frame got bad=%0d frames=%0d want 0/%0d", name, bad, frames, f0); end
        if (err_cnt - e0 != 1)
            begin errors++; $display("FAIL %s_err_pulse got=%0d cycles want=1", name, err_cnt - e0); end
        $display("txn %s read-data rejected err_cycles=%0d", name, err_cnt - e0);
    endtask

    task automatic test_write_addr();
        bit ok;
        exp_t e;
        int gcount, extra;
        logic [7:0] held;
        miso_byte = 8'hFF;
        sb_q.push_back(mk_exp(2'b00, 8'hA5, 8'h00));
        drive_cmd(2'b00, 8'hA5, 1'b0, ok);
        wait_rsp(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wa_rsp got=timeout want=rsp_valid"); return; end
        e = sb_q.pop_front();
        checks += 5;
        if (bus.rsp_data !== e.rsp) begin errors++; $display("FAIL wa_rsp_data got=%02h want=%02h", bus.rsp_data, e.rsp); end
        if (last_len != e.len)      begin errors++; $display("FAIL wa_len got=%0d want=%0d", last_len, e.len); end
        if (last_bits !== e.bits)   begin errors++; $display("FAIL wa_bits got=%h want=%h", last_bits, e.bits); end
        if (last_bits[10:0] !== 11'b000_1010_0101)
            begin errors++; $display("FAIL wa_mosi got=%b want=00010100101", last_bits[10:0]); end
        if (SS_n !== 1'b1) begin errors++; $display("FAIL wa_rsp_ss_n got=%b want=1", SS_n); end
        held = bus.rsp_data;
        gcount = 0;
        extra = 0;
        for (int i = 0; i < 20 && bus.busy === 1'b1; i++) begin
            gcount++;
            if (gcount > 1 && bus.rsp_valid === 1'b1) extra++;
            @(negedge clk);
        end
        checks += 3;
        if (gcount != GAP) begin errors++; $display("FAIL wa_gap got=%0d want=%0d", gcount, GAP); end
        if (extra != 0)    begin errors++; $display("FAIL wa_rsp_width got=%0d extra cycles want=0", extra); end
        if (bus.rsp_data !== held) begin errors++; $display("FAIL wa_rsp_hold got=%02h want=%02h", bus.rsp_data, held); end
        $display("txn write-addr data=a5 len=%0d mosi=%b rsp=%02h", last_len, last_bits[10:0], held);
    endtask

    task automatic test_read();
        bit ok;
        exp_t e;
        logic [1:0] ops [2] = '{2'b10, 2'b11};
        logic [7:0] dat [2] = '{8'h3C, 8'h00};
        miso_byte = 8'hC3;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(mk_exp(ops[i], dat[i], miso_byte));
            drive_cmd(ops[i], dat[i], 1'b0, ok);
            wait_rsp(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rd%0d_rsp got=timeout want=rsp_valid", i); return; end
            e = sb_q.pop_front();
            tb_rd_pend = (e.op == 2'b10) ? 1'b1 : (e.op == 2'b11) ? 1'b0 : tb_rd_pend;
            checks += 3;
            if (bus.rsp_data !== e.rsp) begin errors++; $display("FAIL rd%0d_rsp_data got=%02h want=%02h", i, bus.rsp_data, e.rsp); end
            if (last_len != e.len)      begin errors++; $display("FAIL rd%0d_len got=%0d want=%0d", i, last_len, e.len); end
            if (last_bits !== e.bits)   begin errors++; $display("FAIL rd%0d_bits got=%h want=%h", i, last_bits, e.bits); end
            $display("txn op=%b data=%02h len=%0d rsp=%02h", e.op, dat[i], last_len, bus.rsp_data);
            while (bus.busy === 1'b1) @(negedge clk);
        end
        checks++;
        if (last_len != 21) begin errors++; $display("FAIL rd_frame21 got=%0d want=21", last_len); end
        // rd_pend must now be clear, so another read-data is refused
        test_reject("rd_after_read");
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_t e;
        logic [7:0] dat [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) sb_q.push_back(mk_exp(2'b01, dat[i], 8'h00));
        ready_viol = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(2'b01, dat[i], (i < 2), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b%0d_handshake got=timeout want=accepted", i); end
            if (i > 0) begin
                // GAP cycles in the gap state plus the IDLE cycle that takes the handshake
                checks += 2;
                if (last_gap != GAP + 1)   begin errors++; $display("FAIL b2b%0d_ss_high got=%0d want=%0d", i, last_gap, GAP + 1); end
                if (last_busy_gap != GAP) begin errors++; $display("FAIL b2b%0d_gap_state got=%0d want=%0d", i, last_busy_gap, GAP); end
            end
            wait_rsp(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b%0d_rsp got=timeout want=rsp_valid", i); return; end
            e = sb_q.pop_front();
            checks += 2;
            if (bus.rsp_data !== e.rsp) begin errors++; $display("FAIL b2b%0d_rsp_data got=%02h want=%02h", i, bus.rsp_data, e.rsp); end
            if (last_bits !== e.bits)   begin errors++; $display("FAIL b2b%0d_bits got=%h want=%h", i, last_bits, e.bits); end
            $display("txn write-data data=%02h len=%0d gap=%0d", dat[i], last_len, last_gap);
        end
        while (bus.busy === 1'b1) @(negedge clk);
        checks++;
        if (ready_viol != 0) begin errors++; $display("FAIL b2b_ready_only_idle got=%0d violations want=0", ready_viol); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        exp_t e;
        int r0, e0;
        miso_byte = 8'hFF;
        sb_q.push_back(mk_exp(2'b10, 8'h55, 8'h00));
        drive_cmd(2'b10, 8'h55, 1'b0, ok);
        wait_rsp(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mr_addr_rsp got=timeout want=rsp_valid"); return; end
        e = sb_q.pop_front();
        tb_rd_pend = 1'b1;
        checks++;
        if (last_bits !== e.bits) begin errors++; $display("FAIL mr_addr_bits got=%h want=%h", last_bits, e.bits); end
        $display("txn read-addr data=55 len=%0d", last_len);
        drive_cmd(2'b11, 8'h00, 1'b0, ok);
        for (int i = 0; i < 100 && low_cnt != 12 + TA + 4; i++) @(negedge clk);
        checks++;
        if (low_cnt != 12 + TA + 4) begin errors++; $display("FAIL mr_reach_capture got=%0d want=%0d", low_cnt, 12 + TA + 4); end
        r0 = rsp_cnt;
        e0 = err_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        checks += 2;
        if (SS_n !== 1'b1) begin errors++; $display("FAIL mr_ss_n got=%b want=1", SS_n); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL mr_busy got=%b want=0", bus.busy); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        tb_rd_pend = 1'b0;
        checks++;
        if (rsp_cnt != r0 || err_cnt != e0)
            begin errors++; $display("FAIL mr_no_rsp got rsp=%0d err=%0d want 0/0", rsp_cnt - r0, err_cnt - e0); end
        $display("txn read-data aborted by reset at capture bit 4");
        test_reject("rd_after_abort");
    endtask

    task automatic test_readaddr_override();
        bit ok;
        exp_t e;
        int e0;
        logic [1:0] ops [3] = '{2'b10, 2'b10, 2'b11};
        logic [7:0] dat [3] = '{8'h10, 8'h20, 8'h00};
        miso_byte = 8'h5A;
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(mk_exp(ops[i], dat[i], miso_byte));
            drive_cmd(ops[i], dat[i], 1'b0, ok);
            wait_rsp(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL ov%0d_rsp got=timeout want=rsp_valid", i); return; end
            e = sb_q.pop_front();
            checks += 2;
            if (bus.rsp_data !== e.rsp) begin errors++; $display("FAIL ov%0d_rsp_data got=%02h want=%02h", i, bus.rsp_data, e.rsp); end
            if (last_bits !== e.bits)   begin errors++; $display("FAIL ov%0d_bits got=%h want=%h", i, last_bits, e.bits); end
            if (i == 1) begin
                checks++;
                if (last_bits[9:0] !== 10'b10_0010_0000)
                    begin errors++; $display("FAIL ov_addr_frame got=%b want=1000100000", last_bits[9:0]); end
            end
            $display("txn op=%b data=%02h len=%0d rsp=%02h", e.op, dat[i], last_len, bus.rsp_data);
            while (bus.busy === 1'b1) @(negedge clk);
        end
        checks += 2;
        if (err_cnt != e0) begin errors++; $display("FAIL ov_no_err got=%0d want=0", err_cnt - e0); end
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_empty got=%0d want=0", sb_q.size()); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = 8'h00;
        test_reset();
        test_reject("rd_after_reset");
        test_write_addr();
        test_read();
        test_back_to_back();
        test_reset_midframe();
        test_readaddr_override();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
